// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order ping-pong reorder buffer after the last SDF stage; drops and flags inputs when both banks are full.
// Optional define FFT_REORDER_BYPASS_EN adds a per-write bypass input for natural-order addressing.
module fft_bitrev_reorder #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
`ifdef FFT_REORDER_BYPASS_EN
  input  logic                       bypass,
`endif
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic [logn-1:0]            do_idx,
  output logic                       out_last,
  output logic                       overflow
);

  localparam int N = 1 << logn;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  function automatic logic [logn-1:0] f_bitrev(input logic [logn-1:0] v);
    logic [logn-1:0] r;
    for (int i = 0; i < logn; i++) r[i] = v[logn-1-i];
    return r;
  endfunction

  logic [2*FLOAT_PRECISION-1:0] r_mem [0:2*N-1];

  state_t                       r_state;
  logic [logn-1:0]              r_wr_cnt;
  logic                         r_wr_bank;
  logic [logn-1:0]              r_rd_cnt;
  logic                         r_rd_bank;
  logic [1:0]                   r_bank_full;
  logic                         r_out_valid;
  logic [FLOAT_PRECISION-1:0]   r_do_re;
  logic [FLOAT_PRECISION-1:0]   r_do_im;
  logic [logn-1:0]              r_do_idx;
  logic                         r_out_last;
  logic                         r_overflow;

  logic                         w_hs;
  logic                         w_hs_last;
  logic [1:0]                   w_free;
  logic [1:0]                   w_full_eff;
  logic                         w_wr_en;
  logic                         w_wr_fin;
  logic [1:0]                   w_set;
  logic [logn-1:0]              w_wr_addr;
  logic                         w_ld;
  logic                         w_ld_bank;
  logic [logn-1:0]              w_ld_cnt;
  logic [2*FLOAT_PRECISION-1:0] w_rd_dat;

  assign w_hs       = r_out_valid & out_ready;
  assign w_hs_last  = w_hs & r_out_last;
  // A bank released by this cycle's final read may be written in the same cycle.
  assign w_free[0]  = w_hs_last & ~r_rd_bank;
  assign w_free[1]  = w_hs_last &  r_rd_bank;
  assign w_full_eff = r_bank_full & ~w_free;
  assign w_wr_en    = in_valid & ~w_full_eff[r_wr_bank];
  assign w_wr_fin   = w_wr_en & (r_wr_cnt == '1);
  assign w_set[0]   = w_wr_fin & ~r_wr_bank;
  assign w_set[1]   = w_wr_fin &  r_wr_bank;

`ifdef FFT_REORDER_BYPASS_EN
  assign w_wr_addr = bypass ? r_wr_cnt : f_bitrev(r_wr_cnt);
`else
  assign w_wr_addr = f_bitrev(r_wr_cnt);
`endif

  always_comb begin
    w_ld      = 1'b0;
    w_ld_bank = r_rd_bank;
    w_ld_cnt  = r_rd_cnt;
    case (r_state)
      FETCH: w_ld = 1'b1;
      HOLD: begin
        if (w_hs && !r_out_last) begin
          w_ld     = 1'b1;
          w_ld_cnt = r_rd_cnt + 1'b1;
        end else if (w_hs_last && r_bank_full[~r_rd_bank]) begin
          w_ld      = 1'b1;
          w_ld_bank = ~r_rd_bank;
          w_ld_cnt  = '0;
        end
      end
      default: ;
    endcase
  end

  assign w_rd_dat = r_mem[{w_ld_bank, w_ld_cnt}];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, w_wr_addr}] <= {di_re, di_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_full <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow  <= in_valid & ~w_wr_en;
      r_bank_full <= w_full_eff | w_set;
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_fin) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_out_valid <= 1'b0;
      r_do_re     <= '0;
      r_do_im     <= '0;
      r_do_idx    <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_ld) begin
        r_do_re    <= w_rd_dat[2*FLOAT_PRECISION-1:FLOAT_PRECISION];
        r_do_im    <= w_rd_dat[FLOAT_PRECISION-1:0];
        r_do_idx   <= w_ld_cnt;
        r_out_last <= (w_ld_cnt == '1);
      end
      case (r_state)
        IDLE: begin
          // Look ahead at the completing write so the read starts one cycle earlier.
          if (r_bank_full[r_rd_bank] || w_set[r_rd_bank]) r_state <= FETCH;
        end
        FETCH: begin
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (w_hs_last) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_cnt  <= '0;
            if (!r_bank_full[~r_rd_bank]) begin
              r_out_valid <= 1'b0;
              r_state     <= w_set[~r_rd_bank] ? FETCH : IDLE;
            end
          end else if (w_hs) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign do_re     = r_do_re;
  assign do_im     = r_do_im;
  assign do_idx    = r_do_idx;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with logn=3 (N=8).
module tb_fft_bitrev_reorder;

  localparam int FP   = 64;
  localparam int LOGN = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [FP-1:0] di_re;
  logic [FP-1:0] di_im;
  logic          out_ready;
  logic          out_valid;
  logic [FP-1:0] do_re;
  logic [FP-1:0] do_im;
  logic [LOGN-1:0] do_idx;
  logic          out_last;
  logic          overflow;

  fft_bitrev_reorder #(.FLOAT_PRECISION(FP), .logn(LOGN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .di_re(di_re), .di_im(di_im),
    .out_ready(out_ready), .out_valid(out_valid), .do_re(do_re), .do_im(do_im),
    .do_idx(do_idx), .out_last(out_last), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ovf_cnt   = 0;
  int first_vld = -1;
  int last_in   = 0;
  logic [FP-1:0] rx_re[$];
  logic [FP-1:0] rx_im[$];
  int            rx_idx[$];
  logic          rx_last[$];
  int            rx_cyc[$];
  int tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Samples the current cycle's outputs, then advances to 1 time unit after the next edge.
  task automatic tick();
    if (!rst && out_valid && out_ready) begin
      rx_re.push_back(do_re);
      rx_im.push_back(do_im);
      rx_idx.push_back(int'(do_idx));
      rx_last.push_back(out_last);
      rx_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
    if (out_valid && first_vld < 0) first_vld = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear();
    rx_re.delete(); rx_im.delete(); rx_idx.delete(); rx_last.delete(); rx_cyc.delete();
    first_vld = -1;
    ovf_cnt   = 0;
  endtask

  task automatic send(input logic [63:0] re);
    in_valid = 1'b1;
    di_re    = re;
    di_im    = re + 64'd100;
    last_in  = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gapped);
    for (int j = 0; j < 8; j++) begin
      send(64'(base + tbl[j]));
      if (gapped) repeat ((j % 3) + 1) tick();
    end
  endtask

  task automatic collect(input int n);
    int b = 0;
    while (rx_re.size() < n && b < 400) begin
      tick();
      b++;
    end
    repeat (4) tick();
    chk("rx_count", 64'(rx_re.size()), 64'(n));
  endtask

  task automatic chk_seq(input string tag, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (k < rx_re.size()) begin
        chk({tag, "_re"},   rx_re[k],           64'(base + k));
        chk({tag, "_im"},   rx_im[k],           64'(base + k + 100));
        chk({tag, "_idx"},  64'(rx_idx[k]),     64'(k % 8));
        chk({tag, "_last"}, 64'(rx_last[k]),    64'((k % 8) == 7));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},  64'(out_valid), 64'd0);
    chk({tag, "_re"},   do_re,          64'd0);
    chk({tag, "_im"},   do_im,          64'd0);
    chk({tag, "_idx"},  64'(do_idx),    64'd0);
    chk({tag, "_last"}, 64'(out_last),  64'd0);
    chk({tag, "_ovf"},  64'(overflow),  64'd0);
  endtask

  initial begin
    int b;
    rst = 1'b1; in_valid = 1'b0; di_re = '0; di_im = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Basic reorder and latency.
    clear(); out_ready = 1'b1;
    send_frame(0, 1'b0);
    collect(8);
    chk_seq("t1", 0, 8);
    chk("t1_latency", 64'(first_vld), 64'(last_in + 2));

    // Backpressure at idx 3.
    clear(); out_ready = 1'b1;
    send_frame(0, 1'b0);
    b = 0;
    while (!(out_valid && do_idx == 3) && b < 100) begin tick(); b++; end
    chk("t2_reach", 64'(out_valid && do_idx == 3), 64'd1);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_hold_re", do_re, 64'd3);
      chk("t2_hold_vld", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    collect(8);
    chk_seq("t2", 0, 8);

    // Ping-pong, two back-to-back frames.
    clear(); out_ready = 1'b1;
    send_frame(0, 1'b0);
    send_frame(8, 1'b0);
    collect(16);
    chk_seq("t3", 0, 16);
    if (rx_cyc.size() == 16) chk("t3_nobubble", 64'(rx_cyc[15] - rx_cyc[0]), 64'd15);
    chk("t3_ovf", 64'(ovf_cnt), 64'd0);

    // Overflow with both banks full.
    clear(); out_ready = 1'b0;
    send_frame(0, 1'b0);
    send_frame(8, 1'b0);
    send(64'd99);
    repeat (3) tick();
    chk("t4_ovf_pulses", 64'(ovf_cnt), 64'd1);
    chk("t4_no_out", 64'(rx_re.size()), 64'd0);
    out_ready = 1'b1;
    collect(16);
    chk_seq("t4", 0, 16);

    // Gapped input.
    clear(); out_ready = 1'b1;
    send_frame(0, 1'b1);
    collect(8);
    chk_seq("t5", 0, 8);
    chk("t5_ovf", 64'(ovf_cnt), 64'd0);

    // Reset in the middle of a read.
    clear(); out_ready = 1'b1;
    send_frame(0, 1'b0);
    b = 0;
    while (!(out_valid && do_idx == 4) && b < 100) begin tick(); b++; end
    chk("t6_reach", 64'(out_valid && do_idx == 4), 64'd1);
    rst = 1'b1;
    tick();
    chk_zero("t6_rst");
    rst = 1'b0;
    clear();
    send_frame(20, 1'b0);
    collect(8);
    chk_seq("t6", 20, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
